// File: rtl/parity_stream_acc.sv
// parity_stream_acc: streaming frame-parity accumulator.
// Each WIDTH-bit beat accepted over in_valid/in_ready is XOR-reduced.
// The beat parities are accumulated across a frame that ends on in_last.
// One registered result (parity plus saturating beat count) is then
// presented on a valid/ready output. The result buffer is one deep.
// Optional feature macro: PARITY_ERR_CHK_EN. When it is defined, the
// block adds the in_exp input and the out_err output.
module parity_stream_acc #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             odd_mode,
`ifdef PARITY_ERR_CHK_EN
    input  logic             in_exp,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
`ifdef PARITY_ERR_CHK_EN
    ,
    output logic             out_err
`endif
);

    // The XOR tree is built over a power-of-two leaf count. Unused leaves
    // are padded with zero, which does not change the parity.
    localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 0;
    localparam int P   = 1 << LVL;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic             acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             mode_reg, mode_next;
    logic             out_valid_reg, out_valid_next;
    logic             out_parity_reg, out_parity_next;
    logic [CNT_W-1:0] out_count_reg, out_count_next;
`ifdef PARITY_ERR_CHK_EN
    logic             out_err_reg, out_err_next;
`endif

    logic [P-1:0]     leaves;
    logic             bp;
    logic             accept;
    logic             acc_eff;
    logic             mode_eff;
    logic [CNT_W-1:0] cnt_eff;
    logic [CNT_W-1:0] cnt_inc;

    // Pad the beat out to the tree's leaf count.
    generate
        for (genvar gi = 0; gi < P; gi++) begin : g_leaf
            if (gi < WIDTH) begin : g_data
                assign leaves[gi] = in_data[gi];
            end else begin : g_pad
                assign leaves[gi] = 1'b0;
            end
        end
    endgenerate

    // Reduce the leaves pairwise, one tree level per outer iteration.
    // This gives a balanced tree of depth LVL.
    function automatic logic xor_tree(input logic [P-1:0] v);
        logic [P-1:0] t;
        t = v;
        for (int l = 0; l < LVL; l++) begin
            for (int j = 0; j < (P >> (l + 1)); j++) begin
                t[j] = t[2*j] ^ t[2*j+1];
            end
        end
        return t[0];
    endfunction

    assign bp = xor_tree(leaves);

    // A new beat is allowed only when the result slot is free or is
    // draining this cycle. This also applies to non-last beats, so that
    // results always leave in frame order.
    assign in_ready = !out_valid_reg | out_ready;
    assign accept   = in_valid & in_ready;

    assign out_valid  = out_valid_reg;
    assign out_parity = out_parity_reg;
    assign out_count  = out_count_reg;
`ifdef PARITY_ERR_CHK_EN
    assign out_err    = out_err_reg;
`endif

    // Next-state and datapath logic. In IDLE the running values behave as
    // an empty frame using the live mode. This lets one path handle the
    // first beat, middle beats and the last beat.
    always_comb begin
        state_next      = state_reg;
        acc_next        = acc_reg;
        cnt_next        = cnt_reg;
        mode_next       = mode_reg;
        out_valid_next  = out_valid_reg;
        out_parity_next = out_parity_reg;
        out_count_next  = out_count_reg;
`ifdef PARITY_ERR_CHK_EN
        out_err_next    = out_err_reg;
`endif

        acc_eff  = (state_reg == ACCUM) ? acc_reg  : 1'b0;
        cnt_eff  = (state_reg == ACCUM) ? cnt_reg  : '0;
        mode_eff = (state_reg == ACCUM) ? mode_reg : odd_mode;
        cnt_inc  = (cnt_eff == CNT_MAX) ? CNT_MAX : cnt_eff + CNT_ONE;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                out_valid_next  = 1'b1;
                out_parity_next = (acc_eff ^ bp) ^ mode_eff;
                out_count_next  = cnt_inc;
`ifdef PARITY_ERR_CHK_EN
                out_err_next    = ((acc_eff ^ bp) ^ mode_eff) != in_exp;
`endif
                state_next      = IDLE;
            end else begin
                acc_next   = acc_eff ^ bp;
                cnt_next   = cnt_inc;
                mode_next  = mode_eff;
                state_next = ACCUM;
            end
        end
    end

    // State, accumulator and result registers. Reset drops any open frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= 1'b0;
            cnt_reg        <= '0;
            mode_reg       <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_parity_reg <= 1'b0;
            out_count_reg  <= '0;
`ifdef PARITY_ERR_CHK_EN
            out_err_reg    <= 1'b0;
`endif
        end else begin
            state_reg      <= state_next;
            acc_reg        <= acc_next;
            cnt_reg        <= cnt_next;
            mode_reg       <= mode_next;
            out_valid_reg  <= out_valid_next;
            out_parity_reg <= out_parity_next;
            out_count_reg  <= out_count_next;
`ifdef PARITY_ERR_CHK_EN
            out_err_reg    <= out_err_next;
`endif
        end
    end

endmodule

// File: tb/tb_parity_stream_acc.sv
// tb_parity_stream_acc: directed bench for parity_stream_acc.
// The main instance uses the default parameters. A second instance with
// CNT_W=4 exercises count saturation. Expected frame results are queued
// before each frame is sent and compared when the output handshake fires.
module tb_parity_stream_acc;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_last;
    logic        odd_mode;
    logic        out_valid;
    logic        out_ready;
    logic        out_parity;
    logic [7:0]  out_count;
`ifdef PARITY_ERR_CHK_EN
    logic        in_exp;
    logic        out_err;
`endif

    logic        b_in_valid;
    logic        b_in_ready;
    logic [15:0] b_in_data;
    logic        b_in_last;
    logic        b_odd_mode;
    logic        b_out_valid;
    logic        b_out_ready;
    logic        b_out_parity;
    logic [3:0]  b_out_count;
`ifdef PARITY_ERR_CHK_EN
    logic        b_in_exp;
    logic        b_out_err;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic       par;
        logic [7:0] cnt;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    parity_stream_acc #(.WIDTH(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_last(in_last), .odd_mode(odd_mode),
`ifdef PARITY_ERR_CHK_EN
        .in_exp(in_exp),
`endif
        .out_valid(out_valid), .out_ready(out_ready),
        .out_parity(out_parity), .out_count(out_count)
`ifdef PARITY_ERR_CHK_EN
        , .out_err(out_err)
`endif
    );

    parity_stream_acc #(.WIDTH(16), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_last(b_in_last), .odd_mode(b_odd_mode),
`ifdef PARITY_ERR_CHK_EN
        .in_exp(b_in_exp),
`endif
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_parity(b_out_parity), .out_count(b_out_count)
`ifdef PARITY_ERR_CHK_EN
        , .out_err(b_out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic par, input logic [7:0] cnt, input logic err);
        exp_t e;
        e.par = par;
        e.cnt = cnt;
        e.err = err;
        exp_q.push_back(e);
    endtask

    // Drive one beat and hold it until it is accepted. The number of
    // cycles spent stalled is returned in waited.
    task automatic send_beat(input logic [15:0] d, input logic last, input logic odd,
                             input logic expb, output int waited);
        bit done;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        odd_mode = odd;
`ifdef PARITY_ERR_CHK_EN
        in_exp   = expb;
`else
        if (expb) begin end
`endif
        waited = 0;
        done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 50) begin
                    checks++;
                    errors++;
                    $error("FAIL accept_timeout observed=stalled expected=accepted data=%0h", d);
                    done = 1'b1;
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: one queued result is consumed per output handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_underflow observed=result expected=none");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_parity", 32'(out_parity), 32'(e.par));
                check("sb_count", 32'(out_count), 32'(e.cnt));
`ifdef PARITY_ERR_CHK_EN
                check("sb_err", 32'(out_err), 32'(e.err));
`endif
                $display("result parity=%0d count=%0d", out_parity, out_count);
            end
        end
    end

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0; odd_mode = 1'b0;
        out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_last = 1'b0; b_odd_mode = 1'b0;
        b_out_ready = 1'b1;
`ifdef PARITY_ERR_CHK_EN
        in_exp = 1'b0;
        b_in_exp = 1'b0;
`endif
        #3;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_parity", 32'(out_parity), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        #19 rst = 1'b0;
        @(posedge clk); #1;

        // Single-beat frame, even mode.
        push_exp(1'b1, 8'd1, 1'b0);
        send_beat(16'h0001, 1'b1, 1'b0, 1'b1, w);
        go_idle();
        @(negedge clk);
        check("single_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // Three-beat frame, even then odd mode. In the odd-mode frame, the
        // mode changes after the first beat and must be ignored.
        push_exp(1'b1, 8'd3, 1'b0);
        send_beat(16'hFFFF, 1'b0, 1'b0, 1'b0, w);
        send_beat(16'h0003, 1'b0, 1'b0, 1'b0, w);
        send_beat(16'h0100, 1'b1, 1'b0, 1'b1, w);
        push_exp(1'b0, 8'd3, 1'b0);
        send_beat(16'hFFFF, 1'b0, 1'b1, 1'b0, w);
        send_beat(16'h0003, 1'b0, 1'b0, 1'b0, w);
        send_beat(16'h0100, 1'b1, 1'b0, 1'b0, w);
        // Odd single-beat frame from IDLE uses the live odd_mode.
        push_exp(1'b1, 8'd1, 1'b0);
        send_beat(16'h0000, 1'b1, 1'b1, 1'b1, w);

        // Back-to-back single-beat frames with no stall.
        push_exp(1'b1, 8'd1, 1'b0);
        push_exp(1'b0, 8'd1, 1'b0);
        push_exp(1'b1, 8'd1, 1'b0);
        push_exp(1'b1, 8'd1, 1'b0);
        send_beat(16'h0001, 1'b1, 1'b0, 1'b1, w);
        send_beat(16'h0003, 1'b1, 1'b0, 1'b0, w);
        check("b2b_wait1", 32'(w), 32'd0);
        send_beat(16'h0007, 1'b1, 1'b0, 1'b1, w);
        check("b2b_wait2", 32'(w), 32'd0);
        send_beat(16'h8000, 1'b1, 1'b0, 1'b1, w);
        check("b2b_wait3", 32'(w), 32'd0);
        go_idle();
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: the result is held and the next beat is stalled.
        out_ready = 1'b0;
        push_exp(1'b1, 8'd1, 1'b0);
        push_exp(1'b0, 8'd1, 1'b0);
        send_beat(16'h0001, 1'b1, 1'b0, 1'b1, w);
        in_valid = 1'b1; in_data = 16'h0003; in_last = 1'b1; odd_mode = 1'b0;
`ifdef PARITY_ERR_CHK_EN
        in_exp = 1'b0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_out_parity", 32'(out_parity), 32'd1);
            check("bp_out_count", 32'(out_count), 32'd1);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        go_idle();
        @(negedge clk);
        check("bp_reload_valid", 32'(out_valid), 32'd1);
        check("bp_reload_parity", 32'(out_parity), 32'd0);
        @(posedge clk); #1;

        // Error flag: the frame parity is 1, compared against in_exp.
        push_exp(1'b1, 8'd1, 1'b1);
        send_beat(16'h0007, 1'b1, 1'b0, 1'b0, w);
        push_exp(1'b1, 8'd1, 1'b0);
        send_beat(16'h0007, 1'b1, 1'b0, 1'b1, w);
        go_idle();
        repeat (2) @(posedge clk);
        #1;

        // Reset mid-frame: the partial frame leaves no trace.
        send_beat(16'hFFFF, 1'b0, 1'b1, 1'b0, w);
        send_beat(16'h0001, 1'b0, 1'b0, 1'b0, w);
        go_idle();
        #2 rst = 1'b1;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_no_result", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        push_exp(1'b0, 8'd1, 1'b1);
        send_beat(16'h0003, 1'b1, 1'b0, 1'b1, w);
        go_idle();
        repeat (2) @(posedge clk);
        #1;

        // Count saturation on the CNT_W=4 instance: 20 beats of zeros.
        b_in_valid = 1'b1;
        b_in_data  = 16'h0000;
        for (int i = 0; i < 20; i++) begin
            b_in_last = (i == 19);
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        b_in_last  = 1'b0;
        @(negedge clk);
        check("sat_out_valid", 32'(b_out_valid), 32'd1);
        check("sat_out_count", 32'(b_out_count), 32'd15);
        check("sat_out_parity", 32'(b_out_parity), 32'd0);
`ifdef PARITY_ERR_CHK_EN
        check("sat_out_err", 32'(b_out_err), 32'd0);
`endif
        $display("sat result parity=%0d count=%0d", b_out_parity, b_out_count);

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
